// File: rtl/mult_feed_ctrl.sv
// Input-side sequencer for the multiplier-switch array: one stationary beat, N streaming
// beats, then a fixed drain wait before a one-cycle done pulse.
module mult_feed_ctrl #(
    parameter int unsigned IN_DATA_TYPE = 16,
    parameter int unsigned NUM_PES      = 64,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [CNT_W-1:0]                i_num_stream,
    input  logic                            i_data_valid,
    input  logic [NUM_PES*IN_DATA_TYPE-1:0] i_data_bus,
    output logic                            o_data_ready,
    output logic                            o_valid,
    output logic                            o_stationary,
    output logic [NUM_PES*IN_DATA_TYPE-1:0] o_data_bus,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int unsigned BusW   = NUM_PES * IN_DATA_TYPE;
    localparam int unsigned DrainW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic              valid_q, valid_d;
    logic              stat_q, stat_d;
    logic [BusW-1:0]   data_q, data_d;
    logic              accept;

    // Ready depends on state alone so upstream never sees a combinational loop via valid.
    assign o_data_ready = (state_q == StLoad) || (state_q == StStream);
    assign accept       = i_data_valid && o_data_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        valid_d = 1'b0;
        stat_d  = 1'b0;
        data_d  = data_q;

        if (accept) begin
            valid_d = 1'b1;
            stat_d  = (state_q == StLoad);
            data_d  = i_data_bus;
        end

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    cnt_d   = i_num_stream;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (cnt_q != '0) begin
                        state_d = StStream;
                    end else begin
                        state_d = StDrain;
                        drain_d = DrainW'(DRAIN_CYCLES);
                    end
                end
            end
            StStream: begin
                if (accept) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StDrain;
                        drain_d = DrainW'(DRAIN_CYCLES);
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainW'(1)) begin
                    state_d = StDone;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DrainW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            drain_q <= '0;
            valid_q <= 1'b0;
            stat_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            valid_q <= valid_d;
            stat_q  <= stat_d;
            data_q  <= data_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_stationary = stat_q;
    assign o_data_bus   = data_q;
    assign o_busy       = (state_q != StIdle);
    assign o_done       = (state_q == StDone);

endmodule

// File: tb/tb_mult_feed_ctrl.sv
// Directed bench for mult_feed_ctrl: per-cycle vector table plus a hand-written
// back-to-back job that tracks beat order, latency and the done pulse.
module tb_mult_feed_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned NP = 4;
    localparam int unsigned CW = 16;
    localparam int unsigned DC = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [CW-1:0]     i_num_stream;
    logic              i_data_valid;
    logic [NP*W-1:0]   i_data_bus;
    logic              o_data_ready;
    logic              o_valid;
    logic              o_stationary;
    logic [NP*W-1:0]   o_data_bus;
    logic              o_busy;
    logic              o_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_feed_ctrl #(
        .IN_DATA_TYPE(W),
        .NUM_PES     (NP),
        .CNT_W       (CW),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_num_stream(i_num_stream),
        .i_data_valid(i_data_valid),
        .i_data_bus  (i_data_bus),
        .o_data_ready(o_data_ready),
        .o_valid     (o_valid),
        .o_stationary(o_stationary),
        .o_data_bus  (o_data_bus),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    typedef struct {
        logic          rst;
        logic          start;
        logic [CW-1:0] ns;
        logic          dv;
        logic [W-1:0]  d0;
        logic          e_ready;
        logic          e_valid;
        logic          e_stat;
        logic [W-1:0]  e_d0;
        logic          e_busy;
        logic          e_done;
    } vec_t;

    vec_t vecs[$];

    // Lane k carries lane0 * (k+1), so a zero lane0 gives an all-zero bus.
    function automatic logic [NP*W-1:0] mkbus(input logic [W-1:0] l0);
        logic [NP*W-1:0] b;
        for (int k = 0; k < NP; k++) begin
            b[k*W +: W] = W'(l0 * (k + 1));
        end
        return b;
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic [CW-1:0] ns,
                                input logic dv, input logic [W-1:0] d0, input logic er,
                                input logic ev, input logic es, input logic [W-1:0] ed0,
                                input logic eb, input logic edn);
        vec_t v;
        v.rst = r; v.start = s; v.ns = ns; v.dv = dv; v.d0 = d0;
        v.e_ready = er; v.e_valid = ev; v.e_stat = es; v.e_d0 = ed0;
        v.e_busy = eb; v.e_done = edn;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [NP*W-1:0] act,
                       input logic [NP*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int beats, stats, dones, first_v, last_v, done_cyc, idx;
    logic acc;

    initial begin
        rst = 1'b1; i_start = 1'b0; i_num_stream = '0; i_data_valid = 1'b0; i_data_bus = '0;
        tick();
        tick();
        rst = 1'b0;

        // idle after reset
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0000,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0000,0,0));
        // job: N=3, valid held high
        vecs.push_back(mk(0,1,3,0,16'h0000, 0,0,0,16'h0000,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0011, 1,0,0,16'h0000,1,0));
        vecs.push_back(mk(0,0,0,1,16'h0022, 1,1,1,16'h0011,1,0));
        vecs.push_back(mk(0,0,0,1,16'h0033, 1,1,0,16'h0022,1,0));
        vecs.push_back(mk(0,0,0,1,16'h0044, 1,1,0,16'h0033,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,1,0,16'h0044,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0044,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0044,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0044,1,1));
        // back in idle: restart immediately, N=3, valid toggling
        vecs.push_back(mk(0,1,3,0,16'h0000, 0,0,0,16'h0044,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0011, 1,0,0,16'h0044,1,0));
        vecs.push_back(mk(0,0,0,0,16'hDEAD, 1,1,1,16'h0011,1,0));
        vecs.push_back(mk(0,0,0,1,16'h0022, 1,0,0,16'h0011,1,0));
        vecs.push_back(mk(0,0,0,0,16'hDEAD, 1,1,0,16'h0022,1,0));
        vecs.push_back(mk(0,0,0,1,16'h0033, 1,0,0,16'h0022,1,0));
        vecs.push_back(mk(0,0,0,0,16'hDEAD, 1,1,0,16'h0033,1,0));
        vecs.push_back(mk(0,0,0,1,16'h0044, 1,0,0,16'h0033,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,1,0,16'h0044,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0044,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0044,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0044,1,1));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0044,0,0));
        // N=0: single stationary beat; valid during DRAIN must not be accepted
        vecs.push_back(mk(0,1,0,0,16'h0000, 0,0,0,16'h0044,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0055, 1,0,0,16'h0044,1,0));
        vecs.push_back(mk(0,0,0,1,16'h0066, 0,1,1,16'h0055,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0055,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0055,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0055,1,1));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0055,0,0));
        // start pulses while busy are ignored
        vecs.push_back(mk(0,1,2,0,16'h0000, 0,0,0,16'h0055,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0071, 1,0,0,16'h0055,1,0));
        vecs.push_back(mk(0,1,9,1,16'h0072, 1,1,1,16'h0071,1,0));
        vecs.push_back(mk(0,1,9,1,16'h0073, 1,1,0,16'h0072,1,0));
        vecs.push_back(mk(0,1,9,0,16'h0000, 0,1,0,16'h0073,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0073,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0073,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0073,1,1));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0073,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0073,0,0));
        // reset mid-STREAM, then a normal N=1 job
        vecs.push_back(mk(0,1,5,0,16'h0000, 0,0,0,16'h0073,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0081, 1,0,0,16'h0073,1,0));
        vecs.push_back(mk(0,0,0,1,16'h0082, 1,1,1,16'h0081,1,0));
        vecs.push_back(mk(1,0,0,1,16'h0083, 1,1,0,16'h0082,1,0));
        vecs.push_back(mk(0,0,0,1,16'h0084, 0,0,0,16'h0000,0,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0000,0,0));
        vecs.push_back(mk(0,1,1,0,16'h0000, 0,0,0,16'h0000,0,0));
        vecs.push_back(mk(0,0,0,1,16'h0091, 1,0,0,16'h0000,1,0));
        vecs.push_back(mk(0,0,0,1,16'h0092, 1,1,1,16'h0091,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,1,0,16'h0092,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0092,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0092,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0092,1,1));
        vecs.push_back(mk(0,0,0,0,16'h0000, 0,0,0,16'h0092,0,0));

        foreach (vecs[i]) begin
            rst          = vecs[i].rst;
            i_start      = vecs[i].start;
            i_num_stream = vecs[i].ns;
            i_data_valid = vecs[i].dv;
            i_data_bus   = mkbus(vecs[i].d0);
            #1;
            chk("ready", i, {63'd0, o_data_ready}, {63'd0, vecs[i].e_ready});
            chk("valid", i, {63'd0, o_valid},      {63'd0, vecs[i].e_valid});
            chk("stationary", i, {63'd0, o_stationary}, {63'd0, vecs[i].e_stat});
            chk("data_bus", i, o_data_bus, mkbus(vecs[i].e_d0));
            chk("busy", i, {63'd0, o_busy}, {63'd0, vecs[i].e_busy});
            chk("done", i, {63'd0, o_done}, {63'd0, vecs[i].e_done});
            tick();
        end
        rst = 1'b0; i_start = 1'b0; i_data_valid = 1'b0;

        // Hand-written: N=5 with valid held high; beats must be in order and contiguous.
        beats = 0; stats = 0; dones = 0; first_v = -1; last_v = -1; done_cyc = -1; idx = 0;
        i_start = 1'b1; i_num_stream = 16'd5; i_data_valid = 1'b1;
        i_data_bus = mkbus(16'h00A0);
        tick();
        i_start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (o_valid) begin
                chk("b2b_data", beats, o_data_bus, mkbus(W'(16'h00A0 + beats)));
                if (o_stationary) begin
                    stats++;
                    chk("b2b_stat_first", cyc, 64'(beats), 64'd0);
                end
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                beats++;
            end
            if (o_done) begin
                dones++;
                done_cyc = cyc;
            end
            acc = o_data_ready & i_data_valid;
            tick();
            if (acc) begin
                idx++;
                i_data_bus = mkbus(W'(16'h00A0 + idx));
            end
        end
        i_data_valid = 1'b0;
        chk("b2b_beats", 0, 64'(beats), 64'd6);
        chk("b2b_stationary_count", 0, 64'(stats), 64'd1);
        chk("b2b_done_count", 0, 64'(dones), 64'd1);
        chk("b2b_contiguous", 0, 64'(last_v - first_v), 64'd5);
        chk("b2b_done_latency", 0, 64'(done_cyc - last_v), 64'(DC));
        chk("b2b_idle_busy", 0, {63'd0, o_busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_feed_ctrl.md
# mult_feed_ctrl

Sequencer that drives the input side of the multiplier-switch array: it takes operand vectors from the upstream distribution buffer over a valid/ready handshake. It then issues to the array:
- one stationary-load beat;
- a programmed number of streaming beats;
- a fixed drain wait, so the last products reach the reduction network before completion is signalled.

It sits between the distribution network output and the multiplier array, and generates the array's valid, stationary and data inputs.

## Interface
- IN_DATA_TYPE, 16, bits per operand element
- NUM_PES, 64, number of multiplier switches (vector lanes)
- CNT_W, 16, width of the streaming-beat count
- DRAIN_CYCLES, 3, cycles waited after the last streaming beat before done; must be ≥ 1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_start  in  1  start pulse; sampled only in IDLE
- i_num_stream  in  CNT_W  number of streaming beats after the stationary beat; captured on accepted start
- i_data_valid  in  1  upstream vector valid
- i_data_bus  in  NUM_PES*IN_DATA_TYPE  upstream vector; lane k at [k*IN_DATA_TYPE +: IN_DATA_TYPE]
- o_data_ready  out  1  upstream ready; combinational from state only, never from i_data_valid
- o_valid  out  1  registered beat valid to the multiplier array
- o_stationary  out  1  registered; high only with the stationary-load beat
- o_data_bus  out  NUM_PES*IN_DATA_TYPE  registered vector to the multiplier array
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: wait for i_start.
  - LOAD: accept the stationary beat.
  - STREAM: accept streaming beats.
  - DRAIN: wait for the array to flush.
  - DONE: one-cycle completion state.
- Transitions:
  - IDLE: if i_start, latch i_num_stream into remaining count N and go to LOAD.
  - LOAD: on accept, go to STREAM if N ≠ 0, otherwise go to DRAIN.
  - STREAM: each accept decrements N; the accept that takes N from 1 to 0 moves to DRAIN.
  - DRAIN: load the drain counter with DRAIN_CYCLES on entry; decrement each cycle; go to DONE when the counter reaches 1.
  - DONE: go to IDLE unconditionally.
- o_data_ready = 1 in LOAD and STREAM, 0 in all other states.
- Accept = i_data_valid & o_data_ready.
- Each accept registers i_data_bus into o_data_bus and sets o_valid = 1 on the next cycle.
  - o_stationary is set to 1 on that cycle only when the accept happened in LOAD.
- Cycles without an accept drive o_valid = 0 and o_stationary = 0. o_data_bus holds its last value.
- i_start outside IDLE is ignored; it does not restart or queue a job.
- Only the remaining-count counter and the drain counter are arithmetic. N never underflows: decrement happens only in STREAM, where N ≥ 1.
- The block performs no data transformation; lanes pass through bit-exact.

## Timing
- Reset (synchronous, rst high at a clock edge):
  - state = IDLE;
  - o_valid, o_stationary, o_busy, o_done = 0;
  - o_data_bus = 0;
  - both counters = 0.
- Reset mid-operation aborts the job immediately. No o_done is emitted and partial beats are not replayed.
- Start i_start at cycle t in IDLE:
  - LOAD at t+1, with o_busy = 1 and o_data_ready = 1 from t+1.
- Beat latency: accept at cycle c gives o_valid = 1 at c+1 with the data accepted at c.
- Back-to-back: with i_data_valid held high, one beat is accepted per cycle.
- Last streaming accept at cycle c:
  - DRAIN at c+1, o_data_ready = 0 from c+1;
  - last o_valid at c+1;
  - DONE at c+DRAIN_CYCLES+1, with o_done = 1 in that same cycle;
  - IDLE at c+DRAIN_CYCLES+2, where o_busy = 0.
- o_done is driven from the DONE state (registered state decode). It lasts exactly one cycle.
- A new i_start is honoured the first cycle the block is back in IDLE, so the minimum gap between jobs is one idle cycle.

## Test plan
- Reset, then 2 idle cycles, all inputs low -> every output is 0 and o_data_ready = 0.
- i_num_stream = 3; i_data_valid held high with lane 0 values 0x0011, 0x0022, 0x0033, 0x0044 (NUM_PES=4):
  - o_valid high for 4 consecutive cycles;
  - o_stationary = 1 only on the 0x0011 beat;
  - o_done 3 cycles after the last o_valid (DRAIN_CYCLES=3).
- Same job with i_data_valid toggling 1,0,1,0 -> o_valid shows the same bubbles one cycle later; exactly 4 beats issued; count is not consumed by idle cycles.
- i_num_stream = 0 -> exactly one beat, with o_stationary = 1; then DRAIN; o_done 4 cycles after the accept.
- i_start pulsed during STREAM -> ignored; the beat count stays i_num_stream+1 and there is one o_done.
- rst asserted mid-STREAM after 2 beats -> next cycle all outputs are 0 and there is no o_done. A subsequent job with i_num_stream = 1 completes normally.
